// File: rtl/binary_quiz_game_core.sv
// Fixed-length DIP-switch quiz: draw a target from the RNG, wait for a debounced match, keep score.
// Optional round timeout is enabled by defining TIMEOUT_EN.
module binary_quiz_game_core #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      ROUNDS         = 10,
  parameter logic [WIDTH-1:0] START_CODE     = WIDTH'(1),
  parameter int unsigned      SETTLE_CYCLES  = 4,
  parameter int unsigned      TIMEOUT_CYCLES = 1000,
  localparam int unsigned     CNT_W          = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] user_in,
  output logic             rng_req,
  input  logic [WIDTH-1:0] rng_value,
  output logic [WIDTH-1:0] target,
  output logic             target_valid,
  output logic             hit,
  output logic             miss,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] round_idx,
  output logic             game_active,
  output logic             game_over
);

  // One width serves both PLAY-phase counters (settle and timeout).
  localparam int unsigned PlayMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned PlayW   = $clog2(PlayMax + 1);

  localparam logic [PlayW-1:0] SettleMax = PlayW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RoundsMax = CNT_W'(ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StLoad,
    StPlay,
    StHit,
    StMiss,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PlayW-1:0] settle_q, settle_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             target_valid_q, target_valid_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             rng_req_q, rng_req_d;
  logic             hit_q, hit_d;
  logic             active_q, active_d;
  logic             over_q, over_d;

  logic [CNT_W-1:0] score_inc, round_inc;
  logic [PlayW-1:0] settle_inc;
  logic             match;

`ifdef TIMEOUT_EN
  localparam logic [PlayW-1:0] TimeoutMax = PlayW'(TIMEOUT_CYCLES);
  logic [PlayW-1:0] timer_q, timer_d;
  logic [PlayW-1:0] timer_inc;
  logic             miss_q, miss_d;
  assign timer_inc = timer_q + PlayW'(1);
`endif

  assign score_inc  = (score_q == RoundsMax) ? score_q : score_q + CNT_W'(1);
  assign round_inc  = (round_q == RoundsMax) ? round_q : round_q + CNT_W'(1);
  assign settle_inc = settle_q + PlayW'(1);
  assign match      = (user_in == target_q);

  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    score_d        = score_q;
    round_d        = round_q;
`ifdef TIMEOUT_EN
    timer_d        = timer_q;
`endif

    case (state_q)
      StIdle: begin
        score_d        = '0;
        round_d        = '0;
        target_valid_d = 1'b0;
        if (user_in == START_CODE) state_d = StDraw;
      end
      StDraw: state_d = StLoad;
      StLoad: begin
        // Zero or an already-matching value would give a free hit; draw again.
        if (rng_value == '0 || rng_value == user_in) begin
          state_d = StDraw;
        end else begin
          target_d       = rng_value;
          target_valid_d = 1'b1;
          settle_d       = '0;
`ifdef TIMEOUT_EN
          timer_d        = '0;
`endif
          state_d        = StPlay;
        end
      end
      StPlay: begin
        settle_d = match ? settle_inc : '0;
`ifdef TIMEOUT_EN
        timer_d  = timer_inc;
`endif
        if (match && settle_inc == SettleMax) begin
          state_d        = StHit;
          score_d        = score_inc;
          round_d        = round_inc;
          target_valid_d = 1'b0;
        end
`ifdef TIMEOUT_EN
        else if (timer_inc == TimeoutMax) begin
          state_d        = StMiss;
          round_d        = round_inc;
          target_valid_d = 1'b0;
        end
`endif
      end
      StHit, StMiss: state_d = (round_q == RoundsMax) ? StDone : StDraw;
      StDone: begin
        if (user_in == '0) begin
          state_d = StIdle;
          score_d = '0;
          round_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rng_req_d = (state_d == StDraw);
    hit_d     = (state_d == StHit);
    active_d  = (state_d != StIdle) && (state_d != StDone);
    over_d    = (state_d == StDone);
`ifdef TIMEOUT_EN
    miss_d    = (state_d == StMiss);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      settle_q       <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      score_q        <= '0;
      round_q        <= '0;
      rng_req_q      <= 1'b0;
      hit_q          <= 1'b0;
      active_q       <= 1'b0;
      over_q         <= 1'b0;
`ifdef TIMEOUT_EN
      timer_q        <= '0;
      miss_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      score_q        <= score_d;
      round_q        <= round_d;
      rng_req_q      <= rng_req_d;
      hit_q          <= hit_d;
      active_q       <= active_d;
      over_q         <= over_d;
`ifdef TIMEOUT_EN
      timer_q        <= timer_d;
      miss_q         <= miss_d;
`endif
    end
  end

  assign rng_req      = rng_req_q;
  assign target       = target_q;
  assign target_valid = target_valid_q;
  assign hit          = hit_q;
  assign score        = score_q;
  assign round_idx    = round_q;
  assign game_active  = active_q;
  assign game_over    = over_q;
`ifdef TIMEOUT_EN
  assign miss         = miss_q;
`else
  assign miss         = 1'b0;
`endif

endmodule

// File: tb/tb_binary_quiz_game_core.sv
// Bench for binary_quiz_game_core: phase-level game model checked every cycle plus literal checks.
module tb_binary_quiz_game_core;

  localparam int ROUNDS  = 2;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 8;
  localparam int START   = 1;
`ifdef TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_DRAW = 1, P_LOAD = 2, P_PLAY = 3, P_HIT = 4, P_MISS = 5,
                 P_DONE = 6;

  logic       clk;
  logic       rst_n;
  logic [7:0] user_in;
  logic       rng_req;
  logic [7:0] rng_value;
  logic [7:0] target;
  logic       target_valid;
  logic       hit;
  logic       miss;
  logic [1:0] score;
  logic [1:0] round_idx;
  logic       game_active;
  logic       game_over;

  binary_quiz_game_core #(
    .WIDTH         (8),
    .ROUNDS        (ROUNDS),
    .START_CODE    (8'h01),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .user_in     (user_in),
    .rng_req     (rng_req),
    .rng_value   (rng_value),
    .target      (target),
    .target_valid(target_valid),
    .hit         (hit),
    .miss        (miss),
    .score       (score),
    .round_idx   (round_idx),
    .game_active (game_active),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int req_cnt = 0;
  logic [7:0] rng_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // RNG: answers a request one cycle later from the queue.
  initial begin
    rng_value = 8'h00;
    forever begin
      @(negedge clk);
      if (rng_req === 1'b1) begin
        req_cnt++;
        rng_value = (rng_q.size() > 0) ? rng_q.pop_front() : 8'h77;
      end
    end
  end

  // Game model: tracks which phase of the game the rules put us in.
  int         m_phase = P_IDLE;
  logic [7:0] m_target = 8'h00;
  bit         m_tv = 1'b0;
  int         m_score = 0, m_round = 0, m_run = 0, m_pc = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        m_phase = P_IDLE; m_target = 8'h00; m_tv = 1'b0; m_score = 0; m_round = 0;
      end else begin
        case (m_phase)
          P_IDLE: begin
            m_score = 0; m_round = 0; m_tv = 1'b0;
            if (user_in == 8'(START)) m_phase = P_DRAW;
          end
          P_DRAW: m_phase = P_LOAD;
          P_LOAD: begin
            if (rng_value == 8'h00 || rng_value == user_in) m_phase = P_DRAW;
            else begin
              m_target = rng_value; m_tv = 1'b1; m_run = 0; m_pc = 0; m_phase = P_PLAY;
            end
          end
          P_PLAY: begin
            m_run = (user_in == m_target) ? m_run + 1 : 0;
            m_pc++;
            if (m_run >= SETTLE) begin
              m_phase = P_HIT; m_tv = 1'b0;
              if (m_score < ROUNDS) m_score++;
              if (m_round < ROUNDS) m_round++;
            end else if (TO_EN && m_pc >= TIMEOUT) begin
              m_phase = P_MISS; m_tv = 1'b0;
              if (m_round < ROUNDS) m_round++;
            end
          end
          P_HIT, P_MISS: m_phase = (m_round >= ROUNDS) ? P_DONE : P_DRAW;
          P_DONE: if (user_in == 8'h00) begin
            m_phase = P_IDLE; m_score = 0; m_round = 0;
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("rng_req", rng_req, m_phase == P_DRAW);
        chk("hit", hit, m_phase == P_HIT);
        chk("miss", miss, m_phase == P_MISS);
        chk("game_active", game_active, m_phase >= P_DRAW && m_phase <= P_MISS);
        chk("game_over", game_over, m_phase == P_DONE);
        chk("target_valid", target_valid, m_tv);
        chk("target", target, m_target);
        chk("score", score, m_score);
        chk("round_idx", round_idx, m_round);
      end
    end
  end

  initial begin
    rng_q = {8'h2A, 8'h00, 8'h2A, 8'h13, 8'h5A};
    rst_n = 1'b0;
    user_in = 8'h55;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_target", target, 8'h00);
    chk("rst_valid", target_valid, 1'b0);
    chk("rst_active", game_active, 1'b0);
    chk("rst_over", game_over, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_stay", game_active, 1'b0);

    // Round 1: start, target 0x2A shown two cycles after the start match.
    user_in = 8'h01;
    cyc(3);
    chk("r1_target", target, 8'h2A);
    chk("r1_valid", target_valid, 1'b1);
    chk("r1_reqs", req_cnt, 1);
    user_in = 8'h2A;
    cyc(4);
    chk("r1_hit", hit, 1'b1);
    chk("r1_score", score, 2'd1);
    chk("r1_round", round_idx, 2'd1);

    // Round 2: two redraws (0x00, then 0x2A equal to switches), 0x13 accepted.
    req_cnt = 0;
    for (int i = 0; i < 20 && target_valid !== 1'b1; i++) @(negedge clk);
    chk("r2_valid_wait", target_valid, 1'b1);
    chk("r2_reqs", req_cnt, 3);
    chk("r2_target", target, 8'h13);
    user_in = 8'h13;
    cyc(3);
    user_in = 8'h2B;
    cyc(1);
    chk("r2_broken_nohit", hit, 1'b0);
    chk("r2_broken_score", score, 2'd1);
    user_in = 8'h13;
    cyc(4);
    chk("r2_hit", hit, 1'b1);
    cyc(1);
    chk("done_over", game_over, 1'b1);
    chk("done_score", score, 2'd2);
    user_in = 8'h01;
    cyc(2);
    chk("done_ignores_start", game_over, 1'b1);
    user_in = 8'h00;
    cyc(1);
    chk("back_idle", game_over, 1'b0);
    chk("restart_score", score, 2'd0);

    // Round 3: target 0x5A, switches never match.
    user_in = 8'h01;
    cyc(3);
    chk("r3_target", target, 8'h5A);
`ifdef TIMEOUT_EN
    cyc(TIMEOUT);
    chk("to_miss", miss, 1'b1);
    chk("to_score", score, 2'd0);
    chk("to_round", round_idx, 2'd1);
`else
    cyc(100);
    chk("noto_miss", miss, 1'b0);
    chk("noto_active", game_active, 1'b1);
    chk("noto_valid", target_valid, 1'b1);
`endif

    // Reset mid-game.
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_active", game_active, 1'b0);
    chk("midrst_target", target, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
